// File: rtl/lowest_first_event_dispatcher.sv
// rtl/lowest_first_event_dispatcher.sv - captures rising edges on request lines and
// hands out the lowest pending index over a valid/ready handshake.
module lowest_first_event_dispatcher #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] mask,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             f,
  output logic [WIDTH-1:0] overrun,
  input  logic             clr_overrun
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic             accept;
  logic [IDX_W-1:0] low_idx;

  assign rise   = W & ~w_d & mask;
  assign accept = out_valid & out_ready;

  always_comb begin
    clr = '0;
    if (accept) clr[out_idx] = 1'b1;
  end

  // A fresh edge on the bit being retired this cycle re-arms it.
  assign pending_next = (pending & ~clr) | rise;

  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_d       <= '1;
      pending   <= '0;
      overrun   <= '0;
      f         <= 1'b0;
      state     <= IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      w_d     <= W;
      pending <= pending_next;
      f       <= |pending_next;
      if (clr_overrun) overrun <= '0;
      else             overrun <= overrun | (rise & pending & ~clr);

      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (|pending) begin
            out_idx   <= low_idx;
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (accept) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lowest_first_event_dispatcher.sv
// tb/tb_lowest_first_event_dispatcher.sv - scoreboard bench for the lowest-first event dispatcher.
module tb_lowest_first_event_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] W = '0;
  logic [15:0] mask = 16'hFFFF;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        f;
  logic [15:0] overrun;
  logic        clr_overrun = 1'b0;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  lowest_first_event_dispatcher #(.WIDTH(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .W(W), .mask(mask), .out_ready(out_ready),
    .out_valid(out_valid), .out_idx(out_idx), .f(f), .overrun(overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each handshake that will complete at the next edge retires one expected index.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_accept", int'(out_idx), -1);
      else chk("accept_idx", int'(out_idx), exp_q.pop_front());
    end
  end

  initial begin
    // 1: reset state, single event latency
    tick(2);
    rst = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_f", int'(f), 0);
    chk("rst_overrun", int'(overrun), 0);
    tick();
    W = 16'h0001; out_ready = 1'b1; exp_q.push_back(0);
    tick();
    chk("t1_valid_k", int'(out_valid), 0);
    chk("t1_f_k", int'(f), 1);
    tick();
    chk("t1_valid_k1", int'(out_valid), 1);
    tick();
    chk("t1_f_after", int'(f), 0);
    tick(3);
    chk("t1_no_second", int'(out_valid), 0);
    W = '0; tick();

    // 2: three simultaneous edges, lowest first, one per two cycles
    W = 16'h8420;
    exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(15);
    tick(6);
    chk("t2_last_valid", int'(out_valid), 1);
    chk("t2_last_idx", int'(out_idx), 15);
    tick();
    chk("t2_end_valid", int'(out_valid), 0);
    chk("t2_end_f", int'(f), 0);
    W = '0; tick();

    // 3: stalled presentation is not preempted by a lower index
    out_ready = 1'b0; W = 16'h0008;
    exp_q.push_back(3); exp_q.push_back(1);
    tick(2);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_valid", int'(out_valid), 1);
      chk("t3_stall_idx", int'(out_idx), 3);
      tick();
    end
    W = 16'h000A; tick();
    chk("t3_no_preempt", int'(out_idx), 3);
    out_ready = 1'b1; tick(2);
    chk("t3_next_idx", int'(out_idx), 1);
    tick();
    chk("t3_done_valid", int'(out_valid), 0);
    W = '0; out_ready = 1'b0; tick();

    // 4: overrun, re-arm in accept cycle, clear
    W = 16'h0080; exp_q.push_back(7); exp_q.push_back(7);
    tick(2);
    W = '0; tick();
    W = 16'h0080; tick();
    chk("t4_overrun_set", int'(overrun), 16'h0080);
    clr_overrun = 1'b1; tick();
    chk("t4_overrun_clr", int'(overrun), 0);
    clr_overrun = 1'b0; W = '0; tick();
    W = 16'h0080; out_ready = 1'b1; tick();
    chk("t4_accept_rise_ovr", int'(overrun), 0);
    chk("t4_accept_rise_f", int'(f), 1);
    tick();
    chk("t4_repeat_valid", int'(out_valid), 1);
    chk("t4_repeat_idx", int'(out_idx), 7);
    tick();
    chk("t4_end_valid", int'(out_valid), 0);
    chk("t4_end_f", int'(f), 0);
    W = '0; out_ready = 1'b0; tick();

    // 5: masked edge and line held high across reset release
    mask = 16'hFFFE; W = 16'h0001; tick(3);
    chk("t5_masked_f", int'(f), 0);
    chk("t5_masked_valid", int'(out_valid), 0);
    mask = 16'hFFFF; W = '0; tick();
    rst = 1'b1; W = 16'h0010; tick();
    rst = 1'b0; tick(3);
    chk("t5_held_f", int'(f), 0);
    chk("t5_held_valid", int'(out_valid), 0);

    // 6: reset mid-handshake drops the event in flight
    W = 16'h0014; tick(2);
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_idx", int'(out_idx), 2);
    W = 16'h0010; tick();
    W = 16'h0014; tick();
    chk("t6_overrun", int'(overrun), 16'h0004);
    rst = 1'b1; tick();
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_f", int'(f), 0);
    chk("t6_rst_overrun", int'(overrun), 0);
    rst = 1'b0; tick(3);
    chk("t6_after_valid", int'(out_valid), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
